// File: rtl/trig_pkg.sv
// Shared constants for the trigger qualifier: trigger source modes and FSM state encoding.
package trig_pkg;

    localparam logic [1:0] TRIG_MODE_EXT_PULSE = 2'd0;
    localparam logic [1:0] TRIG_MODE_EXT_LEVEL = 2'd1;
    localparam logic [1:0] TRIG_MODE_SOFT      = 2'd2;
    localparam logic [1:0] TRIG_MODE_RSVD      = 2'd3;

    localparam int TRIG_STATE_W = 2;

    typedef enum logic [TRIG_STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_QUAL     = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_WAIT_REL = 2'd3
    } trig_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser bringing an asynchronous pin into the local clock domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/trig_qualifier.sv
// Trigger front end: synchronises and width-qualifies the external pin, merges pulse/level/software
// sources into registered start/stop events and keeps saturating reject/overrun diagnostics.
module trig_qualifier
    import trig_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH_W     = 24,
    parameter int CNT_W       = 16
) (
    input  logic               io_clk,
    input  logic               io_rst_n,
    input  logic               io_pulseIn,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_trigLow,
    input  logic [WIDTH_W-1:0] cfg_minWidth,
    input  logic               sw_start,
    input  logic               sw_stop,
    input  logic               seq_busy,
    output logic               o_trigStart,
    output logic               o_trigStop,
    output logic               o_trigActive,
    output logic [CNT_W-1:0]   o_rejectCnt,
    output logic [CNT_W-1:0]   o_overrunCnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    localparam logic [WIDTH_W-1:0] ONE_W = {{(WIDTH_W-1){1'b0}}, 1'b1};

    trig_state_e        r_state;
    logic [1:0]         r_mode_q;
    logic               r_trigLow_q;
    logic [WIDTH_W-1:0] r_w_q;
    logic [WIDTH_W-1:0] r_qcnt;

    logic               w_sync;
    logic               w_idle;
    logic               w_act;
    logic               w_ext_live;
    logic [WIDTH_W-1:0] w_wmin;
    logic               w_qual_done;
    logic [WIDTH_W-1:0] w_qcnt_next;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (io_clk),
        .i_rst_n (io_rst_n),
        .i_d     (io_pulseIn),
        .o_q     (w_sync)
    );

    // In IDLE the live configuration is in force; elsewhere the copy captured on the way out of IDLE.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_act       = w_sync ^ (w_idle ? cfg_trigLow : r_trigLow_q);
    assign w_ext_live  = (cfg_mode == TRIG_MODE_EXT_PULSE) || (cfg_mode == TRIG_MODE_EXT_LEVEL);
    assign w_wmin      = (r_w_q == '0) ? ONE_W : r_w_q;
    assign w_qual_done = (r_qcnt >= w_wmin);
    assign w_qcnt_next = (&r_qcnt) ? r_qcnt : r_qcnt + ONE_W;

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_state      <= ST_IDLE;
            r_mode_q     <= TRIG_MODE_EXT_PULSE;
            r_trigLow_q  <= 1'b0;
            r_w_q        <= '0;
            r_qcnt       <= '0;
            o_trigStart  <= 1'b0;
            o_trigStop   <= 1'b0;
            o_trigActive <= 1'b0;
            o_rejectCnt  <= '0;
            o_overrunCnt <= '0;
        end else begin
            o_trigStart <= 1'b0;
            o_trigStop  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mode_q    <= cfg_mode;
                    r_trigLow_q <= cfg_trigLow;
                    r_w_q       <= cfg_minWidth;
                    if (w_ext_live && w_act) begin
                        r_qcnt  <= ONE_W;
                        r_state <= ST_QUAL;
                    end else if ((cfg_mode == TRIG_MODE_SOFT) && sw_start) begin
                        o_trigStart  <= 1'b1;
                        o_trigActive <= 1'b1;
                        r_state      <= ST_ACTIVE;
                    end
                end
                ST_QUAL: begin
                    if (!w_act) begin
                        o_rejectCnt <= sat_inc(o_rejectCnt);
                        r_state     <= ST_IDLE;
                    end else if (w_qual_done) begin
                        if (seq_busy) begin
                            o_overrunCnt <= sat_inc(o_overrunCnt);
                            r_state      <= ST_WAIT_REL;
                        end else if (r_mode_q == TRIG_MODE_EXT_LEVEL) begin
                            o_trigStart  <= 1'b1;
                            o_trigActive <= 1'b1;
                            r_state      <= ST_ACTIVE;
                        end else begin
                            o_trigStart <= 1'b1;
                            r_state     <= ST_WAIT_REL;
                        end
                    end else begin
                        r_qcnt <= w_qcnt_next;
                    end
                end
                ST_ACTIVE: begin
                    if (r_mode_q == TRIG_MODE_EXT_LEVEL) begin
                        if (!w_act) begin
                            o_trigStop   <= 1'b1;
                            o_trigActive <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end else if (r_mode_q == TRIG_MODE_SOFT) begin
                        if (sw_stop) begin
                            o_trigStop   <= 1'b1;
                            o_trigActive <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end else begin
                        // Unreachable for pulse/reserved modes; recover quietly.
                        o_trigActive <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_WAIT_REL: begin
                    if (!w_act) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_qualifier.sv
// Scoreboard bench for trig_qualifier: expected start/stop events are queued with their allowed cycle
// window when stimulus is applied and popped as the DUT emits them.
module tb_trig_qualifier;

    localparam int WW = 24;
    localparam int CW = 8;

    typedef struct {
        logic [1:0] kind;
        int         lo;
        int         hi;
    } exp_t;

    logic          io_clk = 1'b0;
    logic          io_rst_n = 1'b1;
    logic          io_pulseIn = 1'b0;
    logic [1:0]    cfg_mode = 2'd0;
    logic          cfg_trigLow = 1'b0;
    logic [WW-1:0] cfg_minWidth = '0;
    logic          sw_start = 1'b0;
    logic          sw_stop = 1'b0;
    logic          seq_busy = 1'b0;
    logic          o_trigStart;
    logic          o_trigStop;
    logic          o_trigActive;
    logic [CW-1:0] o_rejectCnt;
    logic [CW-1:0] o_overrunCnt;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_start = 0;
    exp_t sb[$];

    localparam logic [1:0] EV_START = 2'b10;
    localparam logic [1:0] EV_STOP  = 2'b01;

    trig_qualifier #(
        .SYNC_STAGES (2),
        .WIDTH_W     (WW),
        .CNT_W       (CW)
    ) dut (
        .io_clk       (io_clk),
        .io_rst_n     (io_rst_n),
        .io_pulseIn   (io_pulseIn),
        .cfg_mode     (cfg_mode),
        .cfg_trigLow  (cfg_trigLow),
        .cfg_minWidth (cfg_minWidth),
        .sw_start     (sw_start),
        .sw_stop      (sw_stop),
        .seq_busy     (seq_busy),
        .o_trigStart  (o_trigStart),
        .o_trigStop   (o_trigStop),
        .o_trigActive (o_trigActive),
        .o_rejectCnt  (o_rejectCnt),
        .o_overrunCnt (o_overrunCnt)
    );

    always #5 io_clk = ~io_clk;
    always @(posedge io_clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_ev(input logic [1:0] kind, input int lo, input int hi);
        exp_t e;
        e.kind = kind;
        e.lo   = lo;
        e.hi   = hi;
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 ns after the edge and retire any emitted event against the queue.
    task automatic step();
        exp_t e;
        @(posedge io_clk);
        #1;
        if (o_trigStart || o_trigStop) begin
            n_vec++;
            if (o_trigStart) n_start++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event cyc=%0d start/stop=%b%b required none", cyc, o_trigStart, o_trigStop);
            end else begin
                e = sb.pop_front();
                if ({o_trigStart, o_trigStop} !== e.kind || cyc < e.lo || cyc > e.hi) begin
                    n_err++;
                    $display("FAIL sb_event cyc=%0d start/stop=%b%b required %b in [%0d,%0d]",
                             cyc, o_trigStart, o_trigStop, e.kind, e.lo, e.hi);
                end
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() > 0 && k < budget) begin
            step();
            k++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #2 io_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_trigStart, o_trigStop, o_trigActive} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags got=%b required 000", {o_trigStart, o_trigStop, o_trigActive});
        end
        n_vec++;
        if (o_rejectCnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_rejectCnt got=%0d required 0", o_rejectCnt);
        end
        n_vec++;
        if (o_overrunCnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_overrunCnt got=%0d required 0", o_overrunCnt);
        end
        steps(3);
        io_rst_n = 1'b1;
        steps(5);
    endtask

    task automatic test_pulse_mode();
        int n;
        int s0;
        cfg_mode = 2'd0;
        cfg_trigLow = 1'b0;
        cfg_minWidth = 24'd80;
        steps(3);
        s0 = n_start;
        for (int r = 0; r < 10; r++) begin
            n = cyc;
            expect_ev(EV_START, n + 2 + 80, n + 3 + 80);
            io_pulseIn = 1'b1;
            steps(150);
            n_vec++;
            if (o_trigActive !== 1'b0) begin
                n_err++;
                $display("FAIL pulse_active rep=%0d got=%b required 0", r, o_trigActive);
            end
            steps(150);
            io_pulseIn = 1'b0;
            steps(300);
        end
        drain(10);
        n_vec++;
        if (n_start - s0 != 10) begin
            n_err++;
            $display("FAIL pulse_start_count got=%0d required 10", n_start - s0);
        end
        cfg_minWidth = 24'd0;
        steps(2);
        n = cyc;
        expect_ev(EV_START, n + 3, n + 4);
        io_pulseIn = 1'b1;
        steps(20);
        io_pulseIn = 1'b0;
        steps(20);
        drain(10);
    endtask

    task automatic test_reject();
        cfg_mode = 2'd0;
        cfg_minWidth = 24'd80;
        steps(3);
        io_pulseIn = 1'b1;
        steps(50);
        io_pulseIn = 1'b0;
        steps(20);
        n_vec++;
        if (o_rejectCnt !== 8'd1) begin
            n_err++;
            $display("FAIL reject_short got=%0d required 1", o_rejectCnt);
        end
        cfg_minWidth = 24'd2;
        steps(3);
        for (int g = 0; g < 100; g++) begin
            io_pulseIn = 1'b1;
            step();
            io_pulseIn = 1'b0;
            step();
        end
        steps(5);
        n_vec++;
        if (o_rejectCnt !== 8'd101) begin
            n_err++;
            $display("FAIL reject_glitch100 got=%0d required 101", o_rejectCnt);
        end
        for (int g = 0; g < 200; g++) begin
            io_pulseIn = 1'b1;
            step();
            io_pulseIn = 1'b0;
            step();
        end
        steps(5);
        n_vec++;
        if (o_rejectCnt !== 8'hFF) begin
            n_err++;
            $display("FAIL reject_saturate got=%0d required 255", o_rejectCnt);
        end
        drain(5);
    endtask

    task automatic test_level(input logic low);
        int n;
        int m;
        cfg_minWidth = 24'd50;
        steps(2);
        n = cyc;
        expect_ev(EV_START, n + 2 + 50, n + 3 + 50);
        io_pulseIn = ~low;
        steps(120);
        n_vec++;
        if (o_trigActive !== 1'b1) begin
            n_err++;
            $display("FAIL level_active_mid low=%b got=%b required 1", low, o_trigActive);
        end
        steps(180);
        io_pulseIn = low;
        m = cyc;
        expect_ev(EV_STOP, m + 3, m + 3);
        steps(2);
        n_vec++;
        if (o_trigActive !== 1'b1) begin
            n_err++;
            $display("FAIL level_active_before_stop low=%b got=%b required 1", low, o_trigActive);
        end
        step();
        n_vec++;
        if (o_trigActive !== 1'b0) begin
            n_err++;
            $display("FAIL level_active_at_stop low=%b got=%b required 0", low, o_trigActive);
        end
        steps(20);
        drain(5);
    endtask

    task automatic test_level_mode();
        cfg_mode = 2'd1;
        cfg_trigLow = 1'b0;
        io_pulseIn = 1'b0;
        steps(3);
        test_level(1'b0);
        cfg_mode = 2'd3;
        io_pulseIn = 1'b1;
        steps(40);
        cfg_trigLow = 1'b1;
        steps(5);
        cfg_mode = 2'd1;
        steps(5);
        test_level(1'b1);
        cfg_trigLow = 1'b0;
        io_pulseIn = 1'b0;
        cfg_mode = 2'd3;
        steps(5);
    endtask

    task automatic sw_cmd(input logic st, input logic sp, input logic [1:0] exp_kind,
                          input logic exp_active, input int id);
        if (exp_kind != 2'b00) expect_ev(exp_kind, cyc + 1, cyc + 1);
        sw_start = st;
        sw_stop  = sp;
        step();
        sw_start = 1'b0;
        sw_stop  = 1'b0;
        n_vec++;
        if (o_trigActive !== exp_active) begin
            n_err++;
            $display("FAIL sw_active step=%0d got=%b required %b", id, o_trigActive, exp_active);
        end
        steps(3);
    endtask

    task automatic test_software();
        cfg_mode = 2'd2;
        steps(3);
        sw_cmd(1'b1, 1'b0, EV_START, 1'b1, 1);
        sw_cmd(1'b1, 1'b0, 2'b00,    1'b1, 2);
        sw_cmd(1'b0, 1'b1, EV_STOP,  1'b0, 3);
        sw_cmd(1'b0, 1'b1, 2'b00,    1'b0, 4);
        sw_cmd(1'b1, 1'b1, EV_START, 1'b1, 5);
        sw_cmd(1'b1, 1'b1, EV_STOP,  1'b0, 6);
        drain(5);
    endtask

    task automatic test_overrun();
        int n;
        int s0;
        cfg_mode = 2'd0;
        cfg_minWidth = 24'd30;
        seq_busy = 1'b1;
        steps(3);
        s0 = n_start;
        io_pulseIn = 1'b1;
        steps(100);
        io_pulseIn = 1'b0;
        steps(50);
        n_vec++;
        if (o_overrunCnt !== 8'd1) begin
            n_err++;
            $display("FAIL overrun_count got=%0d required 1", o_overrunCnt);
        end
        n_vec++;
        if (n_start != s0) begin
            n_err++;
            $display("FAIL overrun_no_start got=%0d required 0", n_start - s0);
        end
        seq_busy = 1'b0;
        n = cyc;
        expect_ev(EV_START, n + 2 + 30, n + 3 + 30);
        io_pulseIn = 1'b1;
        steps(100);
        io_pulseIn = 1'b0;
        steps(50);
        drain(5);
        n_vec++;
        if (o_overrunCnt !== 8'd1) begin
            n_err++;
            $display("FAIL overrun_after_clear got=%0d required 1", o_overrunCnt);
        end
    endtask

    task automatic test_reset_mid_active();
        int n;
        int m;
        cfg_mode = 2'd1;
        cfg_trigLow = 1'b0;
        cfg_minWidth = 24'd10;
        steps(3);
        n = cyc;
        expect_ev(EV_START, n + 12, n + 13);
        io_pulseIn = 1'b1;
        steps(40);
        cfg_mode = 2'd2;
        steps(5);
        io_pulseIn = 1'b0;
        m = cyc;
        expect_ev(EV_STOP, m + 3, m + 3);
        steps(10);
        drain(5);
        cfg_mode = 2'd1;
        steps(2);
        n = cyc;
        expect_ev(EV_START, n + 12, n + 13);
        io_pulseIn = 1'b1;
        steps(40);
        drain(5);
        n_vec++;
        if (o_trigActive !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_active_before got=%b required 1", o_trigActive);
        end
        io_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_trigStart, o_trigStop, o_trigActive} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_flags got=%b required 000", {o_trigStart, o_trigStop, o_trigActive});
        end
        n_vec++;
        if (o_rejectCnt !== 8'd0 || o_overrunCnt !== 8'd0) begin
            n_err++;
            $display("FAIL rstmid_counters got=%0d/%0d required 0/0", o_rejectCnt, o_overrunCnt);
        end
        io_pulseIn = 1'b0;
        steps(5);
        io_rst_n = 1'b1;
        steps(10);
        n_vec++;
        if (o_trigActive !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_after_release got=%b required 0", o_trigActive);
        end
        drain(5);
    endtask

    initial begin
        test_reset();
        test_pulse_mode();
        test_reject();
        test_level_mode();
        test_software();
        test_overrun();
        test_reset_mid_active();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
